// File: rtl/matrix_3x3_ctrl_if.sv
// Pixel-stream interface between the video source, the 3x3 window controller
// and the line buffer / window consumer.
interface matrix_3x3_ctrl_if;
  // Handshake: a pixel is offered when per_frame_clken and per_frame_href are
  // both high on a rising clock edge; there is no back-pressure (no ready), so
  // every qualified strobe is either taken or dropped by the controller.
  logic       per_frame_vsync;
  logic       per_frame_href;
  logic       per_frame_clken;
  logic       lb_href;
  logic       lb_clken;
  logic [9:0] col_cnt;
  logic [9:0] row_cnt;
  logic       win_valid;
  logic       win_first_col;
  logic       win_last_col;
  logic       win_first_row;
  logic       win_last_row;
  logic       frame_done;
  logic       line_err;
  logic [1:0] fsm_state;

  modport master (
    output per_frame_vsync, per_frame_href, per_frame_clken,
    input  lb_href, lb_clken, col_cnt, row_cnt, win_valid,
    input  win_first_col, win_last_col, win_first_row, win_last_row,
    input  frame_done, line_err, fsm_state
  );

  modport slave (
    input  per_frame_vsync, per_frame_href, per_frame_clken,
    output lb_href, lb_clken, col_cnt, row_cnt, win_valid,
    output win_first_col, win_last_col, win_first_row, win_last_row,
    output frame_done, line_err, fsm_state
  );
endinterface

// File: rtl/matrix_3x3_ctrl.sv
// Frame/line sequencer for a 3x3 neighbourhood filter: counts pixels and lines,
// gates line-buffer writes and flags when a full window is available.
module matrix_3x3_ctrl #(
  parameter int H_ACT = 640,
  parameter int V_ACT = 480
) (
  input logic              clk,
  input logic              rst_n,
  matrix_3x3_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LINE = 2'd1,
    LINE      = 2'd2,
    GAP       = 2'd3
  } state_t;

  // Column counter is 11 bits so that saturating at H_ACT=1024 cannot wrap.
  localparam logic [10:0] H_LIM    = 11'(H_ACT);
  localparam logic [9:0]  V_LIM    = 10'(V_ACT);
  localparam logic [9:0]  COL_LAST = 10'(H_ACT - 1);
  localparam logic [9:0]  ROW_LAST = 10'(V_ACT - 2);

  state_t      state;
  logic        vsync_q, href_q;
  logic [10:0] col;
  logic [9:0]  row;
  logic        ovf;
  logic        p1_valid;
  logic [9:0]  p1_col, p1_row;
  logic        lb_href_r, lb_clken_r, win_valid_r, frame_done_r, line_err_r;
  logic        first_col_r, last_col_r, first_row_r, last_row_r;
  logic [9:0]  col_cnt_r, row_cnt_r;

  logic        vs_rise, hr_rise, hr_fall, start_line, in_line, take, extra;
  logic [10:0] col_base;
  logic [9:0]  row_base;

  assign vs_rise    = bus.per_frame_vsync & ~vsync_q;
  assign hr_rise    = bus.per_frame_href & ~href_q;
  assign hr_fall    = ~bus.per_frame_href & href_q;
  // A vsync edge restarts the frame, so a coincident href edge opens row 0.
  assign start_line = hr_rise & (vs_rise | (state == WAIT_LINE) |
                                 ((state == GAP) & (row != V_LIM)));
  assign in_line    = start_line | ((state == LINE) & ~vs_rise & bus.per_frame_href);
  assign col_base   = start_line ? 11'd0 : col;
  assign row_base   = vs_rise ? 10'd0 : row;
  assign take       = in_line & bus.per_frame_href & bus.per_frame_clken & (col_base < H_LIM);
  assign extra      = (state == LINE) & ~vs_rise & bus.per_frame_href &
                      bus.per_frame_clken & (col == H_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      col          <= '0;
      row          <= '0;
      ovf          <= 1'b0;
      p1_valid     <= 1'b0;
      p1_col       <= '0;
      p1_row       <= '0;
      lb_href_r    <= 1'b0;
      lb_clken_r   <= 1'b0;
      win_valid_r  <= 1'b0;
      first_col_r  <= 1'b0;
      last_col_r   <= 1'b0;
      first_row_r  <= 1'b0;
      last_row_r   <= 1'b0;
      frame_done_r <= 1'b0;
      line_err_r   <= 1'b0;
      col_cnt_r    <= '0;
      row_cnt_r    <= '0;
    end else begin
      vsync_q      <= bus.per_frame_vsync;
      href_q       <= bus.per_frame_href;
      lb_href_r    <= bus.per_frame_href;
      lb_clken_r   <= take;
      frame_done_r <= 1'b0;
      line_err_r   <= 1'b0;
      // Rows 0 and 1 only fill the line buffer; the window centre lags by one row.
      p1_valid     <= take && (row_base >= 10'd2);
      if (take) begin
        col    <= col_base + 11'd1;
        p1_col <= col_base[9:0];
        p1_row <= row_base - 10'd1;
      end else if (start_line) begin
        col <= '0;
      end
      win_valid_r <= p1_valid;
      first_col_r <= p1_valid && (p1_col == 10'd0);
      last_col_r  <= p1_valid && (p1_col == COL_LAST);
      first_row_r <= p1_valid && (p1_row == 10'd1);
      last_row_r  <= p1_valid && (p1_row == ROW_LAST);
      if (p1_valid) begin
        col_cnt_r <= p1_col;
        row_cnt_r <= p1_row;
      end
      if (vs_rise) begin
        row <= '0;
        ovf <= 1'b0;
        if (hr_rise) begin
          state <= LINE;
        end else begin
          state <= WAIT_LINE;
          col   <= '0;
        end
      end else begin
        case (state)
          WAIT_LINE: if (hr_rise) begin
            state <= LINE;
            ovf   <= 1'b0;
          end
          LINE: begin
            if (extra) ovf <= 1'b1;
            if (hr_fall) begin
              state      <= GAP;
              row        <= row + 10'd1;
              line_err_r <= (col != H_LIM) || ovf;
            end
          end
          GAP: if (row == V_LIM) begin
            state        <= IDLE;
            frame_done_r <= 1'b1;
          end else if (hr_rise) begin
            state <= LINE;
            ovf   <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.lb_href       = lb_href_r;
  assign bus.lb_clken      = lb_clken_r;
  assign bus.col_cnt       = col_cnt_r;
  assign bus.row_cnt       = row_cnt_r;
  assign bus.win_valid     = win_valid_r;
  assign bus.win_first_col = first_col_r;
  assign bus.win_last_col  = last_col_r;
  assign bus.win_first_row = first_row_r;
  assign bus.win_last_row  = last_row_r;
  assign bus.frame_done    = frame_done_r;
  assign bus.line_err      = line_err_r;
  assign bus.fsm_state     = state;
endmodule

// File: tb/tb_matrix_3x3_ctrl.sv
// Bench for matrix_3x3_ctrl with an 8x4 frame: scenario tasks plus a window
// scoreboard fed from the frame/line/pixel structure the bench drives.
module tb_matrix_3x3_ctrl;
  localparam int H = 8;
  localparam int V = 4;
  localparam int W = 40;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  matrix_3x3_ctrl_if bus();
  matrix_3x3_ctrl #(.H_ACT(H), .V_ACT(V)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0, failures = 0;
  int exp_clk = 0, obs_clk = 0, exp_err = 0, obs_err = 0;
  int exp_fd = 0, obs_fd = 0, obs_win = 0;
  // entry: {cycle[15:0], centre row[9:0], col[9:0], first_col, last_col, first_row, last_row}
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_obs, mon_exp;

  function automatic logic [W-1:0] win_word(input int c, input int row, input int col);
    logic [9:0] r;
    r = 10'(row - 1);
    return {16'(c), r, 10'(col), col == 0, col == H - 1, (row - 1) == 1, (row - 1) == V - 2};
  endfunction

  // scoreboard / monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.lb_clken)   obs_clk++;
      if (bus.line_err)   obs_err++;
      if (bus.frame_done) obs_fd++;
      while (exp_q.size() > 0 && int'(exp_q[0][39:24]) < cyc) begin
        checks++; failures++;
        $display("FAIL window_missed got=none want=%h at cyc=%0d", exp_q.pop_front(), cyc);
      end
      mon_obs = {16'(cyc), bus.row_cnt, bus.col_cnt, bus.win_first_col, bus.win_last_col,
                 bus.win_first_row, bus.win_last_row};
      if (bus.win_valid) begin
        obs_win++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL window_unexpected got=%h want=none", mon_obs);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_obs !== mon_exp) begin
            failures++;
            $display("FAIL window got=%h want=%h", mon_obs, mon_exp);
          end
        end
      end else begin
        checks++;
        if (mon_obs[3:0] !== 4'b0) begin
          failures++;
          $display("FAIL flags_idle got=%b want=0000 at cyc=%0d", mon_obs[3:0], cyc);
        end
      end
    end
  end

  // driver tasks
  task automatic step(input logic vs, input logic hr, input logic ck);
    @(negedge clk);
    bus.per_frame_vsync = vs;
    bus.per_frame_href  = hr;
    bus.per_frame_clken = ck;
  endtask

  task automatic settle();
    repeat (6) step(1'b0, 1'b0, 1'b0);
    #1;
  endtask

  task automatic vsync_pulse();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  // mode 0 continuous strobes, 1 every other cycle, 2 random
  task automatic drive_line(input int row, input int npix, input int mode,
                            input bit vs_first, input bit live, input int gap);
    int s = 0;
    int t = 0;
    bit ck;
    while (s < npix) begin
      case (mode)
        0:       ck = 1'b1;
        1:       ck = (t % 2 == 0);
        default: ck = 1'($urandom_range(0, 1));
      endcase
      step(vs_first && t == 0, 1'b1, ck);
      if (ck) begin
        if (live && s < H) begin
          exp_clk++;
          if (row >= 2) exp_q.push_back(win_word(cyc + 2, row, s));
        end
        s++;
      end
      t++;
    end
    if (live && npix != H) exp_err++;
    for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic drive_frame(input int mode, input bit vs_with_href,
                             input int l0, input int l1, input int l2, input int l3);
    int lens[4];
    lens = '{l0, l1, l2, l3};
    if (!vs_with_href) vsync_pulse();
    for (int r = 0; r < V; r++)
      drive_line(r, lens[r], mode, vs_with_href && r == 0, 1'b1,
                 (r == V - 1) ? 4 : 2 + int'($urandom_range(0, 3)));
    exp_fd++;
  endtask

  // scenarios
  task automatic test_reset();
    bus.per_frame_vsync = 1'b0;
    bus.per_frame_href  = 1'b0;
    bus.per_frame_clken = 1'b0;
    repeat (2) step(1'b1, 1'b1, 1'b1);
    #1;
    checks++;
    if ({bus.lb_href, bus.lb_clken, bus.win_valid, bus.win_first_col, bus.win_last_col,
         bus.win_first_row, bus.win_last_row, bus.frame_done, bus.line_err} !== 9'b0) begin
      failures++; $display("FAIL reset_flags got=nonzero want=0");
    end
    checks++;
    if ({bus.col_cnt, bus.row_cnt} !== 20'b0) begin
      failures++; $display("FAIL reset_counts got=%0d/%0d want=0/0", bus.col_cnt, bus.row_cnt);
    end
    checks++;
    if (bus.fsm_state !== 2'd0) begin
      failures++; $display("FAIL reset_state got=%0d want=0", bus.fsm_state);
    end
    step(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_continuous();
    int w0 = obs_win;
    int f0 = obs_fd;
    drive_frame(0, 1'b0, 8, 8, 8, 8);
    settle();
    checks++; if (obs_win - w0 != 16) begin failures++; $display("FAIL cont_windows got=%0d want=16", obs_win - w0); end
    checks++; if (obs_fd - f0 != 1) begin failures++; $display("FAIL cont_frame_done got=%0d want=1", obs_fd - f0); end
    checks++; if (obs_clk != exp_clk) begin failures++; $display("FAIL cont_lb_clken got=%0d want=%0d", obs_clk, exp_clk); end
    checks++; if (obs_err != exp_err) begin failures++; $display("FAIL cont_line_err got=%0d want=%0d", obs_err, exp_err); end
  endtask

  task automatic test_alternate();
    int w0 = obs_win;
    drive_frame(1, 1'b0, 8, 8, 8, 8);
    settle();
    checks++; if (obs_win - w0 != 16) begin failures++; $display("FAIL alt_windows got=%0d want=16", obs_win - w0); end
    checks++; if (obs_fd != exp_fd) begin failures++; $display("FAIL alt_frame_done got=%0d want=%0d", obs_fd, exp_fd); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL alt_pending got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_line_err();
    int c0 = obs_clk;
    int e0 = obs_err;
    int w0 = obs_win;
    drive_frame(0, 1'b0, 8, 6, 10, 8);
    settle();
    checks++; if (obs_err - e0 != 2) begin failures++; $display("FAIL lerr_pulses got=%0d want=2", obs_err - e0); end
    checks++; if (obs_clk - c0 != 30) begin failures++; $display("FAIL lerr_lb_clken got=%0d want=30", obs_clk - c0); end
    checks++; if (obs_win - w0 != 16) begin failures++; $display("FAIL lerr_windows got=%0d want=16", obs_win - w0); end
    checks++; if (obs_fd != exp_fd) begin failures++; $display("FAIL lerr_frame_done got=%0d want=%0d", obs_fd, exp_fd); end
  endtask

  task automatic test_abort();
    int f0 = obs_fd;
    int w0 = obs_win;
    vsync_pulse();
    drive_line(0, 8, 0, 1'b0, 1'b1, 2);
    drive_line(1, 8, 0, 1'b0, 1'b1, 2);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b1);
      exp_clk++;
      exp_q.push_back(win_word(cyc + 2, 2, k));
    end
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (obs_fd != f0) begin failures++; $display("FAIL abort_no_done got=%0d want=%0d", obs_fd, f0); end
    for (int r = 0; r < V; r++) drive_line(r, 8, 0, 1'b0, 1'b1, (r == V - 1) ? 4 : 3);
    exp_fd++;
    settle();
    checks++; if (obs_win - w0 != 20) begin failures++; $display("FAIL abort_windows got=%0d want=20", obs_win - w0); end
    checks++; if (obs_fd - f0 != 1) begin failures++; $display("FAIL abort_frame_done got=%0d want=1", obs_fd - f0); end
    checks++; if (obs_clk != exp_clk) begin failures++; $display("FAIL abort_lb_clken got=%0d want=%0d", obs_clk, exp_clk); end
  endtask

  task automatic test_reset_mid();
    int c0, f0, e0;
    vsync_pulse();
    for (int r = 0; r < 3; r++) drive_line(r, 8, 0, 1'b0, 1'b1, 2);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b1);
      exp_clk++;
      exp_q.push_back(win_word(cyc + 2, 3, k));
    end
    step(1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.lb_href, bus.lb_clken, bus.win_valid, bus.win_first_col, bus.win_last_col,
         bus.win_first_row, bus.win_last_row, bus.frame_done, bus.line_err} !== 9'b0) begin
      failures++; $display("FAIL midreset_flags got=nonzero want=0");
    end
    checks++;
    if ({bus.col_cnt, bus.row_cnt, bus.fsm_state} !== 22'b0) begin
      failures++; $display("FAIL midreset_counts got=%0d/%0d/%0d want=0/0/0", bus.col_cnt, bus.row_cnt, bus.fsm_state);
    end
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    rst_n = 1'b1;
    c0 = obs_clk; f0 = obs_fd; e0 = obs_err;
    repeat (3) step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    drive_line(0, 8, 0, 1'b0, 1'b0, 3);
    drive_line(1, 8, 0, 1'b0, 1'b0, 3);
    settle();
    checks++; if (obs_clk != c0) begin failures++; $display("FAIL midreset_lb_clken got=%0d want=%0d", obs_clk, c0); end
    checks++; if (obs_fd != f0 || obs_err != e0) begin failures++; $display("FAIL midreset_pulses got=%0d/%0d want=%0d/%0d", obs_fd, obs_err, f0, e0); end
    checks++; if (obs_clk != exp_clk) begin failures++; $display("FAIL midreset_total_clken got=%0d want=%0d", obs_clk, exp_clk); end
  endtask

  task automatic test_same_cycle();
    int c0 = obs_clk;
    int w0 = obs_win;
    drive_frame(0, 1'b1, 8, 8, 8, 8);
    settle();
    checks++; if (obs_clk - c0 != 32) begin failures++; $display("FAIL same_lb_clken got=%0d want=32", obs_clk - c0); end
    checks++; if (obs_win - w0 != 16) begin failures++; $display("FAIL same_windows got=%0d want=16", obs_win - w0); end
    checks++; if (obs_fd != exp_fd) begin failures++; $display("FAIL same_frame_done got=%0d want=%0d", obs_fd, exp_fd); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      drive_frame(2, 1'($urandom_range(0, 1)),
                  int'($urandom_range(7, 9)), int'($urandom_range(7, 9)),
                  int'($urandom_range(7, 9)), int'($urandom_range(7, 9)));
      repeat (int'($urandom_range(1, 5))) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    end
    settle();
    checks++; if (obs_clk != exp_clk) begin failures++; $display("FAIL rand_lb_clken got=%0d want=%0d", obs_clk, exp_clk); end
    checks++; if (obs_err != exp_err) begin failures++; $display("FAIL rand_line_err got=%0d want=%0d", obs_err, exp_err); end
    checks++; if (obs_fd != exp_fd) begin failures++; $display("FAIL rand_frame_done got=%0d want=%0d", obs_fd, exp_fd); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rand_pending got=%0d want=0", exp_q.size()); end
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_continuous();
    test_alternate();
    test_line_err();
    test_abort();
    test_reset_mid();
    test_same_cycle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
